// File: rtl/i2c_avalon_regs.sv
`default_nettype none
// i2c_avalon_regs: Avalon-MM register front end for the I2C byte engine.
// Command FIFO toward the core, receive FIFO from it, divider and irq. Rev 1.0
module i2c_avalon_regs #(
  parameter int          CMD_DEPTH    = 8,
  parameter int          RX_DEPTH     = 8,
  parameter logic [31:0] CLKDIV_RESET = 32'd249
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic [31:0] clk_div,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_data,
  output logic        cmd_nack,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_nack
);
  localparam int          CAW          = $clog2(CMD_DEPTH);
  localparam int          RAW          = $clog2(RX_DEPTH);
  localparam logic [CAW:0] CMD_FULL_CNT = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW:0] RX_FULL_CNT  = (RAW+1)'(RX_DEPTH);
  localparam logic [1:0]  OP_READ      = 2'd2;

  logic          r_en, r_irq_en, r_nack_err, r_rx_ovf, r_cmd_ovf;
  logic [31:0]   r_clkdiv, r_rdata;
  logic [1:0]    r_last_op;
  logic [10:0]   r_cmd_mem [CMD_DEPTH];
  logic [7:0]    r_rx_mem  [RX_DEPTH];
  logic [CAW-1:0] r_cmd_wp, r_cmd_rp;
  logic [CAW:0]   r_cmd_cnt;
  logic [RAW-1:0] r_rx_wp, r_rx_rp;
  logic [RAW:0]   r_rx_cnt;

  logic w_wr_ctrl, w_wr_stat, w_wr_div, w_wr_cmd, w_flush;
  logic w_cmd_full, w_cmd_empty, w_rx_full, w_rx_empty, w_busy;
  logic w_cmd_pop, w_cmd_push, w_rx_req, w_rx_pop, w_rx_push;
  logic [31:0] w_rdata;

  assign w_wr_ctrl = avs_write && (avs_address == 3'd0);
  assign w_wr_stat = avs_write && (avs_address == 3'd1);
  assign w_wr_div  = avs_write && (avs_address == 3'd2);
  assign w_wr_cmd  = avs_write && (avs_address == 3'd3);
  assign w_flush   = w_wr_ctrl && avs_writedata[2];

  assign w_cmd_full  = (r_cmd_cnt == CMD_FULL_CNT);
  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign w_rx_full   = (r_rx_cnt == RX_FULL_CNT);
  assign w_rx_empty  = (r_rx_cnt == '0);
  assign w_busy      = !w_cmd_empty || !cmd_ready;

  assign cmd_valid  = r_en && !w_cmd_empty;
  assign w_cmd_pop  = cmd_valid && cmd_ready;
  assign w_cmd_push = w_wr_cmd && (!w_cmd_full || w_cmd_pop);
  // Responses are classified by the op dispatched before this cycle's pop.
  assign w_rx_req   = rsp_valid && (r_last_op == OP_READ);
  assign w_rx_pop   = avs_read && (avs_address == 3'd4) && !w_rx_empty;
  assign w_rx_push  = w_rx_req && (!w_rx_full || w_rx_pop);

  assign cmd_op    = r_cmd_mem[r_cmd_rp][9:8];
  assign cmd_data  = r_cmd_mem[r_cmd_rp][7:0];
  assign cmd_nack  = r_cmd_mem[r_cmd_rp][10];
  assign clk_div   = r_clkdiv;
  assign avs_readdata = r_rdata;
  assign irq = r_irq_en && (r_nack_err || r_rx_ovf || r_cmd_ovf || !w_rx_empty);

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      3'd0: w_rdata = {30'd0, r_irq_en, r_en};
      3'd1: w_rdata = {24'd0, r_cmd_ovf, r_rx_ovf, r_nack_err, w_busy,
                       w_rx_full, w_rx_empty, w_cmd_empty, w_cmd_full};
      3'd2: w_rdata = r_clkdiv;
      3'd4: w_rdata = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rp]};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_cmd_push && !w_flush) r_cmd_mem[r_cmd_wp] <= avs_writedata[10:0];
    if (w_rx_push && !w_flush)  r_rx_mem[r_rx_wp]   <= rsp_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_nack_err <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_cmd_ovf  <= 1'b0;
      r_clkdiv   <= CLKDIV_RESET;
      r_rdata    <= '0;
      r_last_op  <= 2'd0;
      r_cmd_wp   <= '0;
      r_cmd_rp   <= '0;
      r_cmd_cnt  <= '0;
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_cnt   <= '0;
    end else begin
      if (avs_read) r_rdata <= w_rdata;
      if (w_wr_ctrl) begin
        r_en     <= avs_writedata[0];
        r_irq_en <= avs_writedata[1];
      end
      if (w_wr_div) r_clkdiv <= avs_writedata;
      if (w_cmd_pop) r_last_op <= cmd_op;

      // Sticky flags: a same-cycle set beats the write-1-to-clear.
      r_nack_err <= (r_nack_err && !(w_wr_stat && avs_writedata[5])) || (rsp_valid && rsp_nack);
      r_rx_ovf   <= (r_rx_ovf && !(w_wr_stat && avs_writedata[6]))
                    || (w_rx_req && w_rx_full && !w_rx_pop);
      r_cmd_ovf  <= (r_cmd_ovf && !(w_wr_stat && avs_writedata[7]))
                    || (w_wr_cmd && w_cmd_full && !w_cmd_pop);

      if (w_flush) begin
        r_cmd_wp  <= '0;
        r_cmd_rp  <= '0;
        r_cmd_cnt <= '0;
        r_rx_wp   <= '0;
        r_rx_rp   <= '0;
        r_rx_cnt  <= '0;
      end else begin
        if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CAW'(1);
        if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CAW'(1);
        if (w_cmd_push && !w_cmd_pop)      r_cmd_cnt <= r_cmd_cnt + (CAW+1)'(1);
        else if (!w_cmd_push && w_cmd_pop) r_cmd_cnt <= r_cmd_cnt - (CAW+1)'(1);
        if (w_rx_push) r_rx_wp <= r_rx_wp + RAW'(1);
        if (w_rx_pop)  r_rx_rp <= r_rx_rp + RAW'(1);
        if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + (RAW+1)'(1);
        else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - (RAW+1)'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_i2c_avalon_regs.sv
`default_nettype none
// tb_i2c_avalon_regs: directed-vector bench for the I2C Avalon register block.
module tb_i2c_avalon_regs;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata, clk_div;
  logic        irq, cmd_valid, cmd_nack;
  logic        cmd_ready = 1'b1;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid = 1'b0, rsp_nack = 1'b0;
  logic [7:0]  rsp_data = '0;

  int n_vec = 0;
  int n_err = 0;

  i2c_avalon_regs #(.CMD_DEPTH(8), .RX_DEPTH(8), .CLKDIV_RESET(32'd249)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .clk_div(clk_div),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic rsp_pulse(input logic [7:0] d, input logic nk);
    rsp_valid = 1'b1; rsp_data = d; rsp_nack = nk;
    @(posedge clk); #1;
    rsp_valid = 1'b0; rsp_nack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (avs_readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata: got %h want 0", avs_readdata); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    bus_read(3'd2, rd);
    n_vec++; if (rd !== 32'h0000_00F9) begin n_err++; $display("FAIL reset_clkdiv: got %h want 000000f9", rd); end
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h06) begin n_err++; $display("FAIL reset_status: got %h want 06", rd); end
    bus_read(3'd0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", rd); end
  endtask

  task automatic test_dispatch();
    logic [31:0] rd;
    logic [1:0]  ops [3];
    logic [7:0]  dat [3];
    int n = 0;
    bus_write(3'd0, 32'h3);
    cmd_ready = 1'b0;
    bus_write(3'd3, 32'h000);
    n_vec++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL cmd_valid_latency: got %b want 1", cmd_valid); end
    bus_write(3'd3, 32'h1A0);
    bus_write(3'd3, 32'h300);
    cmd_ready = 1'b1;
    for (int t = 0; t < 20 && n < 3; t++) begin
      if (cmd_valid) begin ops[n] = cmd_op; dat[n] = cmd_data; n++; end
      @(posedge clk); #1;
    end
    n_vec++;
    if (n != 3) begin n_err++; $display("FAIL dispatch_count: got %0d want 3", n); end
    else begin
      if (ops[0] !== 2'd0 || ops[1] !== 2'd1 || ops[2] !== 2'd3) begin
        n_err++; $display("FAIL dispatch_ops: got %0d %0d %0d want 0 1 3", ops[0], ops[1], ops[2]);
      end
      n_vec++; if (dat[1] !== 8'hA0) begin n_err++; $display("FAIL dispatch_data: got %h want a0", dat[1]); end
    end
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h06) begin n_err++; $display("FAIL dispatch_status: got %h want 06", rd); end
  endtask

  task automatic test_read_rsp();
    logic [31:0] rd;
    bus_write(3'd3, 32'h600);
    n_vec++; if ({cmd_valid, cmd_op, cmd_nack} !== 4'b1101) begin
      n_err++; $display("FAIL read_head: got v%b op%0d nk%b want v1 op2 nk1", cmd_valid, cmd_op, cmd_nack);
    end
    @(posedge clk); #1;
    rsp_pulse(8'h5C, 1'b0);
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL rx_irq_high: got %b want 1", irq); end
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h02) begin n_err++; $display("FAIL rx_status_pending: got %h want 02", rd); end
    bus_read(3'd4, rd);
    n_vec++; if (rd !== 32'h5C) begin n_err++; $display("FAIL rxdata: got %h want 5c", rd); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rx_irq_low: got %b want 0", irq); end
    bus_read(3'd4, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rxdata_empty: got %h want 0", rd); end
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h06) begin n_err++; $display("FAIL rx_status_empty: got %h want 06", rd); end
  endtask

  task automatic test_nack_and_rx_ovf();
    logic [31:0] rd;
    bus_write(3'd3, 32'h155);
    @(posedge clk); #1;
    rsp_pulse(8'h00, 1'b1);
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h26) begin n_err++; $display("FAIL nack_err_set: got %h want 26", rd); end
    bus_write(3'd1, 32'h20);
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h06) begin n_err++; $display("FAIL nack_err_clr: got %h want 06", rd); end
    bus_write(3'd3, 32'h200);
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      rsp_valid = 1'b1; rsp_data = 8'h10 + 8'(i);
      @(posedge clk); #1;
    end
    rsp_valid = 1'b0;
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h4A) begin n_err++; $display("FAIL rx_ovf_status: got %h want 4a", rd); end
    for (int i = 0; i < 8; i++) begin
      bus_read(3'd4, rd);
      n_vec++; if (rd !== 32'h10 + i) begin n_err++; $display("FAIL rx_order[%0d]: got %h want %h", i, rd, 32'h10 + i); end
    end
    bus_write(3'd1, 32'h40);
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h06) begin n_err++; $display("FAIL rx_ovf_clr: got %h want 06", rd); end
  endtask

  task automatic test_cmd_ovf_and_flush();
    logic [31:0] rd;
    cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(3'd3, 32'h100 + i);
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h95) begin n_err++; $display("FAIL cmd_ovf_status: got %h want 95", rd); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL cmd_ovf_irq: got %b want 1", irq); end
    n_vec++; if (cmd_data !== 8'h00) begin n_err++; $display("FAIL cmd_head_kept: got %h want 00", cmd_data); end
    bus_write(3'd1, 32'h80);
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h15) begin n_err++; $display("FAIL cmd_ovf_clr: got %h want 15", rd); end
    bus_write(3'd0, 32'h7);
    n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", cmd_valid); end
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h16) begin n_err++; $display("FAIL flush_status: got %h want 16", rd); end
    bus_read(3'd0, rd);
    n_vec++; if (rd !== 32'h3) begin n_err++; $display("FAIL flush_ctrl: got %h want 3", rd); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    bus_write(3'd2, 32'h0000_1234);
    n_vec++; if (clk_div !== 32'h1234) begin n_err++; $display("FAIL clkdiv_write: got %h want 1234", clk_div); end
    bus_write(3'd3, 32'h000);
    bus_read(3'd2, rd);
    n_vec++; if (cmd_valid !== 1'b1 || rd !== 32'h1234) begin
      n_err++; $display("FAIL pre_reset: got v%b rd %h want v1 rd 1234", cmd_valid, rd);
    end
    #3 reset_n = 1'b0;
    #1;
    n_vec++; if ({cmd_valid, irq} !== 2'b00 || clk_div !== 32'hF9 || avs_readdata !== 32'h0) begin
      n_err++; $display("FAIL async_reset: got v%b irq%b div %h rd %h want v0 irq0 div f9 rd 0",
                        cmd_valid, irq, clk_div, avs_readdata);
    end
    cmd_ready = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    bus_read(3'd1, rd);
    n_vec++; if (rd !== 32'h06) begin n_err++; $display("FAIL post_reset_status: got %h want 06", rd); end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_read_rsp();
    test_nack_and_rx_ovf();
    test_cmd_ovf_and_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
